// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the UART transceiver.
//   parity_mode_t      - run-time parity selection (2'b11 decodes as NONE)
//   tx_state_t         - transmit FSM states
//   rx_state_t         - receive FSM states
//   decode_parity_mode - maps the raw 2-bit port value onto parity_mode_t
//   calc_parity        - parity bit for a data word under a given mode
package uart_pkg;

   localparam int unsigned MAX_DATA_BITS = 9;

   typedef enum logic [1:0] {
      NONE = 2'b00,
      EVEN = 2'b01,
      ODD  = 2'b10
   } parity_mode_t;

   typedef enum logic {
      TxIdle,
      TxShift
   } tx_state_t;

   typedef enum logic [2:0] {
      RxIdle,
      RxStart,
      RxData,
      RxParity,
      RxStop,
      RxWaitHigh
   } rx_state_t;

   function automatic parity_mode_t decode_parity_mode(input logic [1:0] mode);
      case (mode)
         2'b01:   return EVEN;
         2'b10:   return ODD;
         default: return NONE;
      endcase
   endfunction

   // Narrow words are zero-extended by the caller, which leaves the XOR unchanged.
   function automatic logic calc_parity(input logic [MAX_DATA_BITS-1:0] data,
                                        input parity_mode_t             mode);
      case (mode)
         EVEN:    return ^data;
         ODD:     return ~(^data);
         default: return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/uart_rx_core.sv
// uart_rx_core: receive path of the UART transceiver.
//   clk, reset       - system clock, asynchronous active-high reset
//   clk_enable       - oversample tick; every FSM decision happens on a tick
//   parity_mode      - raw parity selection, latched at start detect
//   rx_uart          - asynchronous serial input (2-flop synchronised here)
//   rx_data_valid    - one-cycle pulse when a frame completes
//   rx_data          - last received word
//   rx_parity_error  - parity mismatch on last frame
//   rx_frame_error   - first stop bit sampled low
//   rx_break         - line held low through the whole frame
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clk_enable,
   input  logic [1:0]           parity_mode,
   input  logic                 rx_uart,
   output logic                 rx_data_valid,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_parity_error,
   output logic                 rx_frame_error,
   output logic                 rx_break
);

   localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
   localparam int unsigned IDX_W = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] SAMP_A    = CNT_W'(OVERSAMPLE / 2 - 1);
   localparam logic [CNT_W-1:0] SAMP_B    = CNT_W'(OVERSAMPLE / 2);
   localparam logic [CNT_W-1:0] SAMP_C    = CNT_W'(OVERSAMPLE / 2 + 1);
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OVERSAMPLE - 1);
   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

   logic                 sync1_q, sync2_q;
   rx_state_t            state_q;
   logic [CNT_W-1:0]     cnt_q;
   logic [IDX_W-1:0]     idx_q;
   logic [1:0]           vote_q;
   logic [DATA_BITS-1:0] shift_q;
   logic                 par_bit_q;
   parity_mode_t         mode_q;

   logic bit_maj, at_mid, at_last, par_err, is_break;

   // vote_q holds the first two samples; the third is the live synchronised value.
   always_comb begin
      bit_maj  = (vote_q[1] & vote_q[0]) | (vote_q[1] & sync2_q) | (vote_q[0] & sync2_q);
      at_mid   = (cnt_q == SAMP_C);
      at_last  = (cnt_q == TICK_LAST);
      par_err  = (mode_q != NONE) &&
                 (par_bit_q != calc_parity(MAX_DATA_BITS'(shift_q), mode_q));
      is_break = !bit_maj && (shift_q == '0) && ((mode_q == NONE) || !par_bit_q);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
      end else begin
         sync1_q <= rx_uart;
         sync2_q <= sync1_q;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= RxIdle;
         cnt_q           <= '0;
         idx_q           <= '0;
         vote_q          <= '0;
         shift_q         <= '0;
         par_bit_q       <= 1'b0;
         mode_q          <= NONE;
         rx_data_valid   <= 1'b0;
         rx_data         <= '0;
         rx_parity_error <= 1'b0;
         rx_frame_error  <= 1'b0;
         rx_break        <= 1'b0;
      end else begin
         rx_data_valid <= 1'b0;
         if (clk_enable) begin
            if (state_q != RxIdle && state_q != RxWaitHigh) begin
               cnt_q <= at_last ? '0 : cnt_q + 1'b1;
               if (cnt_q == SAMP_A || cnt_q == SAMP_B) vote_q <= {vote_q[0], sync2_q};
            end
            case (state_q)
               RxIdle: begin
                  if (!sync2_q) begin
                     // The detecting tick is tick 0 of the start bit.
                     state_q <= RxStart;
                     cnt_q   <= CNT_W'(1);
                     idx_q   <= '0;
                     mode_q  <= decode_parity_mode(parity_mode);
                  end
               end
               RxStart: begin
                  if (at_mid && bit_maj) state_q <= RxIdle;
                  else if (at_last)      state_q <= RxData;
               end
               RxData: begin
                  if (at_mid) shift_q <= {bit_maj, shift_q[DATA_BITS-1:1]};
                  if (at_last) begin
                     if (idx_q == IDX_LAST) state_q <= (mode_q == NONE) ? RxStop : RxParity;
                     else                   idx_q   <= idx_q + 1'b1;
                  end
               end
               RxParity: begin
                  if (at_mid)  par_bit_q <= bit_maj;
                  if (at_last) state_q   <= RxStop;
               end
               RxStop: begin
                  if (at_mid) begin
                     rx_data_valid   <= 1'b1;
                     rx_data         <= shift_q;
                     rx_parity_error <= par_err;
                     rx_frame_error  <= !bit_maj;
                     rx_break        <= is_break;
                     // A break must see the line high again before re-arming.
                     state_q         <= is_break ? RxWaitHigh : RxIdle;
                  end
               end
               RxWaitHigh: begin
                  if (sync2_q) state_q <= RxIdle;
               end
               default: state_q <= RxIdle;
            endcase
         end
      end
   end

endmodule

// File: rtl/uart_transceiver.sv
// uart_transceiver: full-duplex UART with configurable width, oversampling and stop bits.
//   clk, reset       - system clock, asynchronous active-high reset
//   clk_enable       - oversample tick (OVERSAMPLE ticks per bit)
//   parity_mode      - 00 none, 01 even, 10 odd, 11 none; latched per frame
//   tx_data_valid/tx_data_ready/tx_data - client word handshake, LSB first on the wire
//   tx_uart, tx_busy - serial output (idles high), frame in progress
//   rx_uart          - serial input
//   rx_data_valid, rx_data, rx_parity_error, rx_frame_error, rx_break - received frame
module uart_transceiver
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned OVERSAMPLE = 16,
   parameter int unsigned STOP_BITS  = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 clk_enable,
   input  logic [1:0]           parity_mode,
   input  logic                 rx_uart,
   output logic                 tx_uart,
   input  logic                 tx_data_valid,
   output logic                 tx_data_ready,
   input  logic [DATA_BITS-1:0] tx_data,
   output logic                 tx_busy,
   output logic                 rx_data_valid,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_parity_error,
   output logic                 rx_frame_error,
   output logic                 rx_break
);

   localparam int unsigned CNT_W   = $clog2(OVERSAMPLE);
   localparam int unsigned FRAME_W = DATA_BITS + STOP_BITS + 2;
   localparam int unsigned IDX_W   = $clog2(FRAME_W);
   localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(OVERSAMPLE - 1);

   parity_mode_t       req_mode;
   logic [FRAME_W-1:0] frame;
   logic [IDX_W-1:0]   frame_last;

   // Frame image, LSB transmitted first; bits above the parity slot stay 1 (stop bits).
   always_comb begin
      req_mode           = decode_parity_mode(parity_mode);
      frame              = '1;
      frame[0]           = 1'b0;
      frame[DATA_BITS:1] = tx_data;
      if (req_mode != NONE) begin
         frame[DATA_BITS+1] = calc_parity(MAX_DATA_BITS'(tx_data), req_mode);
      end
      frame_last = IDX_W'(DATA_BITS + STOP_BITS) + ((req_mode != NONE) ? IDX_W'(1) : IDX_W'(0));
   end

   tx_state_t          tx_state_q;
   logic [FRAME_W-1:0] tx_shift_q;
   logic [CNT_W-1:0]   tx_cnt_q;
   logic [IDX_W-1:0]   tx_idx_q;
   logic [IDX_W-1:0]   tx_last_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_state_q    <= TxIdle;
         tx_shift_q    <= '1;
         tx_cnt_q      <= '0;
         tx_idx_q      <= '0;
         tx_last_q     <= '0;
         tx_uart       <= 1'b1;
         tx_data_ready <= 1'b0;
         tx_busy       <= 1'b0;
      end else begin
         case (tx_state_q)
            TxIdle: begin
               tx_uart <= 1'b1;
               // The handshake does not wait for a tick.
               if (tx_data_valid && tx_data_ready) begin
                  tx_uart       <= 1'b0;
                  tx_shift_q    <= frame >> 1;
                  tx_cnt_q      <= '0;
                  tx_idx_q      <= '0;
                  tx_last_q     <= frame_last;
                  tx_data_ready <= 1'b0;
                  tx_busy       <= 1'b1;
                  tx_state_q    <= TxShift;
               end else begin
                  tx_data_ready <= 1'b1;
               end
            end
            TxShift: begin
               if (clk_enable) begin
                  if (tx_cnt_q == TICK_LAST) begin
                     tx_cnt_q <= '0;
                     if (tx_idx_q == tx_last_q) begin
                        tx_uart       <= 1'b1;
                        tx_data_ready <= 1'b1;
                        tx_busy       <= 1'b0;
                        tx_state_q    <= TxIdle;
                     end else begin
                        tx_uart    <= tx_shift_q[0];
                        tx_shift_q <= tx_shift_q >> 1;
                        tx_idx_q   <= tx_idx_q + 1'b1;
                     end
                  end else begin
                     tx_cnt_q <= tx_cnt_q + 1'b1;
                  end
               end
            end
            default: tx_state_q <= TxIdle;
         endcase
      end
   end

   uart_rx_core #(
      .DATA_BITS  (DATA_BITS),
      .OVERSAMPLE (OVERSAMPLE)
   ) u_rx (
      .clk             (clk),
      .reset           (reset),
      .clk_enable      (clk_enable),
      .parity_mode     (parity_mode),
      .rx_uart         (rx_uart),
      .rx_data_valid   (rx_data_valid),
      .rx_data         (rx_data),
      .rx_parity_error (rx_parity_error),
      .rx_frame_error  (rx_frame_error),
      .rx_break        (rx_break)
   );

endmodule
